// File: rtl/idma_2d_midend_pkg.sv
// Shared types for the 2D iDMA midend: request/response structs, FSM encoding and
// the job-size helper.
package idma_2d_midend_pkg;

  localparam int unsigned RepWidth = 32;
  localparam int unsigned TotWidth = 2 * RepWidth;

  typedef logic [31:0]         addr_t;
  typedef logic [RepWidth-1:0] reps_t;
  typedef logic [TotWidth-1:0] total_t;

  typedef struct packed {
    addr_t      src_addr;
    addr_t      dst_addr;
    addr_t      length;
    logic [7:0] opt;
  } req_t;

  typedef struct packed {
    logic error;
  } rsp_t;

  typedef struct packed {
    req_t  burst_req;
    addr_t src_1d_stride;
    addr_t dst_1d_stride;
    addr_t src_2d_stride;
    addr_t dst_2d_stride;
    reps_t num_1d_reps;
    reps_t num_2d_reps;
  } nd_req_t;

  localparam logic StIdle  = 1'b0;
  localparam logic StIssue = 1'b1;

  function automatic total_t job_total(input reps_t n1, input reps_t n2);
    return total_t'(n1) * total_t'(n2);
  endfunction

endpackage

// File: rtl/idma_2d_midend_if.sv
// Handshake bundle between the ND request source, the 1D backend and the midend.
interface idma_2d_midend_if;
  import idma_2d_midend_pkg::*;

  nd_req_t nd_req;
  logic    nd_req_valid;
  logic    nd_req_ready;
  rsp_t    nd_rsp;
  logic    nd_rsp_valid;
  logic    nd_rsp_ready;
  req_t    burst_req;
  logic    burst_req_valid;
  logic    burst_req_ready;
  rsp_t    burst_rsp;
  logic    burst_rsp_valid;
  logic    burst_rsp_ready;

  modport slave (
    input  nd_req, nd_req_valid, nd_rsp_ready, burst_req_ready, burst_rsp, burst_rsp_valid,
    output nd_req_ready, nd_rsp, nd_rsp_valid, burst_req, burst_req_valid, burst_rsp_ready
  );

  modport master (
    output nd_req, nd_req_valid, nd_rsp_ready, burst_req_ready, burst_rsp, burst_rsp_valid,
    input  nd_req_ready, nd_rsp, nd_rsp_valid, burst_req, burst_req_valid, burst_rsp_ready
  );

endinterface

// File: rtl/idma_2d_midend_fifo.sv
// Small synchronous FIFO holding the burst count of each outstanding ND job.
module idma_2d_midend_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [Width-1:0] data_in,
  input  logic             pop,
  output logic [Width-1:0] data_out,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  rd_q, wr_q;
  logic [CntW-1:0]  cnt_q;
  logic             do_push, do_pop;

  assign full     = (cnt_q == CntW'(Depth));
  assign empty    = (cnt_q == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign data_out = mem_q[rd_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= (wr_q == PtrW'(Depth - 1)) ? '0 : wr_q + PtrW'(1);
      if (do_pop)  rd_q <= (rd_q == PtrW'(Depth - 1)) ? '0 : rd_q + PtrW'(1);
      if (do_push && !do_pop)      cnt_q <= cnt_q + CntW'(1);
      else if (do_pop && !do_push) cnt_q <= cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_in;
  end

endmodule

// File: rtl/idma_2d_midend.sv
// Expands 2D iDMA jobs into 1D bursts and folds the burst responses back into one
// response per job.
module idma_2d_midend
  import idma_2d_midend_pkg::*;
#(
  parameter int unsigned NumOutstanding = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  idma_2d_midend_if.slave   bus,
  output logic              busy
);

  logic    state_q;
  nd_req_t nd_q;
  reps_t   i_q, j_q;
  addr_t   src_row_q, dst_row_q, src_cur_q, dst_cur_q;
  logic    fifo_full, fifo_empty;
  total_t  push_total, head_total, rsp_cnt_q, rsp_cnt_inc;
  logic    err_acc_q, nd_rsp_valid_q;
  rsp_t    nd_rsp_q;
  logic    nd_hs, burst_hs, rsp_hs, row_last, complete;

  assign nd_hs      = bus.nd_req_valid && bus.nd_req_ready;
  assign burst_hs   = bus.burst_req_valid && bus.burst_req_ready;
  assign rsp_hs     = bus.burst_rsp_valid && bus.burst_rsp_ready;
  assign row_last   = (i_q == nd_q.num_1d_reps - reps_t'(1));
  assign push_total = job_total(bus.nd_req.num_1d_reps, bus.nd_req.num_2d_reps);

  assign bus.nd_req_ready    = (state_q == StIdle) && !fifo_full;
  assign bus.burst_req_valid = (state_q == StIssue);
  assign bus.nd_rsp_valid    = nd_rsp_valid_q;
  assign bus.nd_rsp          = nd_rsp_q;
  assign bus.burst_rsp_ready = !nd_rsp_valid_q && !fifo_empty;
  assign busy = (state_q == StIssue) || !fifo_empty || nd_rsp_valid_q;

  always_comb begin
    bus.burst_req          = nd_q.burst_req;
    bus.burst_req.src_addr = src_cur_q;
    bus.burst_req.dst_addr = dst_cur_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      nd_q      <= '0;
      i_q       <= '0;
      j_q       <= '0;
      src_row_q <= '0;
      dst_row_q <= '0;
      src_cur_q <= '0;
      dst_cur_q <= '0;
    end else if (nd_hs) begin
      nd_q      <= bus.nd_req;
      i_q       <= '0;
      j_q       <= '0;
      src_row_q <= bus.nd_req.burst_req.src_addr;
      dst_row_q <= bus.nd_req.burst_req.dst_addr;
      src_cur_q <= bus.nd_req.burst_req.src_addr;
      dst_cur_q <= bus.nd_req.burst_req.dst_addr;
      state_q   <= (push_total != '0) ? StIssue : StIdle;
    end else if (burst_hs) begin
      if (!row_last) begin
        i_q       <= i_q + reps_t'(1);
        src_cur_q <= src_cur_q + nd_q.src_1d_stride;
        dst_cur_q <= dst_cur_q + nd_q.dst_1d_stride;
      end else begin
        // Row done: the next burst starts from the advanced row base.
        i_q       <= '0;
        src_row_q <= src_row_q + nd_q.src_2d_stride;
        dst_row_q <= dst_row_q + nd_q.dst_2d_stride;
        src_cur_q <= src_row_q + nd_q.src_2d_stride;
        dst_cur_q <= dst_row_q + nd_q.dst_2d_stride;
        if (j_q == nd_q.num_2d_reps - reps_t'(1)) state_q <= StIdle;
        else                                       j_q     <= j_q + reps_t'(1);
      end
    end
  end

  idma_2d_midend_fifo #(
    .Depth (NumOutstanding),
    .Width (TotWidth)
  ) i_job_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (nd_hs),
    .data_in  (push_total),
    .pop      (complete),
    .data_out (head_total),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Zero-burst jobs complete as soon as they reach the head.
  assign rsp_cnt_inc = rsp_cnt_q + total_t'(1);
  assign complete    = (!fifo_empty && !nd_rsp_valid_q && head_total == '0) ||
                       (rsp_hs && rsp_cnt_inc == head_total);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nd_rsp_valid_q <= 1'b0;
      nd_rsp_q       <= '0;
      rsp_cnt_q      <= '0;
      err_acc_q      <= 1'b0;
    end else begin
      if (bus.nd_rsp_valid && bus.nd_rsp_ready) nd_rsp_valid_q <= 1'b0;
      if (complete) begin
        nd_rsp_valid_q <= 1'b1;
        nd_rsp_q.error <= err_acc_q | (rsp_hs & bus.burst_rsp.error);
        rsp_cnt_q      <= '0;
        err_acc_q      <= 1'b0;
      end else if (rsp_hs) begin
        rsp_cnt_q <= rsp_cnt_inc;
        err_acc_q <= err_acc_q | bus.burst_rsp.error;
      end
    end
  end

  a_rsp_without_job: assert property (@(posedge clk) disable iff (!rst_n)
    bus.burst_rsp_valid |-> !fifo_empty);

endmodule

// File: tb/tb_idma_2d_midend.sv
// Scoreboard bench for idma_2d_midend: expected bursts and job responses are queued
// when jobs are driven and checked as the DUT hands them out.
module tb_idma_2d_midend;
  import idma_2d_midend_pkg::*;

  typedef struct packed {
    addr_t src;
    addr_t dst;
    addr_t len;
    logic  err;
  } exp_burst_t;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;

  exp_burst_t exp_burst_q[$];
  logic       exp_nd_q[$];
  logic       pend_rsp_q[$];

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int first_hs, last_hs;
  bit saw_bvalid;
  bit rsp_en  = 1'b1;
  bit rand_bp = 1'b0;

  always #5 clk = ~clk;

  idma_2d_midend_if bus_if ();

  idma_2d_midend #(
    .NumOutstanding (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if),
    .busy  (busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: handshakes sampled mid-cycle, before the edge that commits them.
  always @(negedge clk) begin : mon
    exp_burst_t e;
    logic       ex;
    cyc++;
    if (rst_n) begin
      if (bus_if.burst_req_valid) saw_bvalid = 1'b1;
      if (bus_if.burst_req_valid && bus_if.burst_req_ready) begin
        if (exp_burst_q.size() == 0) begin
          check_eq("burst_unexpected", 1, 0);
        end else begin
          e = exp_burst_q.pop_front();
          check_eq("burst_src", bus_if.burst_req.src_addr, e.src);
          check_eq("burst_dst", bus_if.burst_req.dst_addr, e.dst);
          check_eq("burst_len", bus_if.burst_req.length, e.len);
          pend_rsp_q.push_back(e.err);
        end
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
      end
      if (bus_if.burst_rsp_valid && bus_if.burst_rsp_ready && pend_rsp_q.size() > 0)
        void'(pend_rsp_q.pop_front());
      if (bus_if.nd_rsp_valid && bus_if.nd_rsp_ready) begin
        if (exp_nd_q.size() == 0) begin
          check_eq("nd_rsp_unexpected", 1, 0);
        end else begin
          ex = exp_nd_q.pop_front();
          check_eq("nd_rsp_error", bus_if.nd_rsp.error, ex);
        end
      end
    end
  end

  // Backend model: answers accepted bursts in order.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n || !rsp_en || pend_rsp_q.size() == 0 || (rand_bp && $urandom_range(0, 3) == 0))
      begin
        bus_if.burst_rsp_valid = 1'b0;
        bus_if.burst_rsp.error = 1'b0;
      end else begin
        bus_if.burst_rsp_valid = 1'b1;
        bus_if.burst_rsp.error = pend_rsp_q[0];
      end
      if (rand_bp) bus_if.burst_req_ready = 1'($urandom_range(0, 1));
    end
  end

  function automatic nd_req_t mk(input addr_t src, input addr_t dst, input addr_t len,
                                 input addr_t s1s, input addr_t s1d, input addr_t s2s,
                                 input addr_t s2d, input reps_t n1, input reps_t n2);
    nd_req_t r;
    r                    = '0;
    r.burst_req.src_addr = src;
    r.burst_req.dst_addr = dst;
    r.burst_req.length   = len;
    r.burst_req.opt      = 8'h5a;
    r.src_1d_stride      = s1s;
    r.dst_1d_stride      = s1d;
    r.src_2d_stride      = s2s;
    r.dst_2d_stride      = s2d;
    r.num_1d_reps        = n1;
    r.num_2d_reps        = n2;
    return r;
  endfunction

  task automatic expect_job(input nd_req_t r, input int err_idx);
    exp_burst_t e;
    int   k   = 0;
    logic any = 1'b0;
    for (int jj = 0; jj < int'(r.num_2d_reps); jj++) begin
      for (int ii = 0; ii < int'(r.num_1d_reps); ii++) begin
        e.src = r.burst_req.src_addr + addr_t'(jj) * r.src_2d_stride
                + addr_t'(ii) * r.src_1d_stride;
        e.dst = r.burst_req.dst_addr + addr_t'(jj) * r.dst_2d_stride
                + addr_t'(ii) * r.dst_1d_stride;
        e.len = r.burst_req.length;
        e.err = (k == err_idx);
        any   = any | e.err;
        exp_burst_q.push_back(e);
        k++;
      end
    end
    exp_nd_q.push_back(any);
  endtask

  task automatic drive_job(input nd_req_t r);
    bit ok = 1'b0;
    bus_if.nd_req       = r;
    bus_if.nd_req_valid = 1'b1;
    for (int w = 0; w < 400 && !ok; w++) begin
      @(negedge clk);
      if (bus_if.nd_req_ready) ok = 1'b1;
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end else begin
      check_eq("nd_req_accept_timeout", 0, 1);
    end
    bus_if.nd_req_valid = 1'b0;
  endtask

  task automatic send_job(input nd_req_t r, input int err_idx);
    expect_job(r, err_idx);
    drive_job(r);
  endtask

  task automatic drain(input string tag);
    int w = 0;
    while ((exp_nd_q.size() != 0 || busy) && w < 2000) begin
      @(negedge clk);
      w++;
    end
    check_eq({tag, "_drained"}, (w < 2000), 1);
    check_eq({tag, "_bursts_left"}, exp_burst_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    nd_req_t r;
    bit      found, stable;
    logic    err0;
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    nd_req_t r, r3;
    bit      found, stable;
    logic    err0;
    rst_n                  = 1'b0;
    bus_if.nd_req          = '0;
    bus_if.nd_req_valid    = 1'b0;
    bus_if.nd_rsp_ready    = 1'b1;
    bus_if.burst_req_ready = 1'b1;
    bus_if.burst_rsp       = '0;
    bus_if.burst_rsp_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_burst_valid", bus_if.burst_req_valid, 0);
    check_eq("rst_nd_rsp_valid", bus_if.nd_rsp_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_nd_req_ready", bus_if.nd_req_ready, 1);
    check_eq("rst_burst_rsp_ready", bus_if.burst_rsp_ready, 0);
    @(posedge clk);
    #1;

    // 1: single row, four back-to-back bursts
    first_hs = -1;
    send_job(mk(32'h1000, 32'h2000, 32'd64, 32'h100, 32'h100, 32'h0, 32'h0, 4, 1), -1);
    drain("t1");
    check_eq("t1_back_to_back", last_hs - first_hs, 3);

    // 2: 2x3 grid with distinct src/dst strides
    send_job(mk(32'h0, 32'h8000, 32'd16, 32'h10, 32'h20, 32'h1000, 32'h4000, 2, 3), -1);
    drain("t2");

    // 3: zero inner reps
    saw_bvalid = 1'b0;
    expect_job(mk(32'h0, 32'h0, 32'd8, 32'h4, 32'h4, 32'h40, 32'h40, 0, 5), -1);
    drive_job(mk(32'h0, 32'h0, 32'd8, 32'h4, 32'h4, 32'h40, 32'h40, 0, 5));
    found = 1'b0;
    for (int k = 0; k < 2 && !found; k++) begin
      @(negedge clk);
      if (bus_if.nd_rsp_valid) found = 1'b1;
    end
    check_eq("t3_rsp_within_2", found, 1);
    drain("t3");
    check_eq("t3_no_burst", saw_bvalid, 0);

    // 4: error on the second burst, then a clean job
    send_job(mk(32'h3000, 32'h4000, 32'd32, 32'h20, 32'h20, 32'h0, 32'h0, 3, 1), 1);
    send_job(mk(32'h5000, 32'h6000, 32'd32, 32'h20, 32'h20, 32'h0, 32'h0, 3, 1), -1);
    drain("t4");

    // 5: job FIFO full stalls the third request
    rsp_en = 1'b0;
    send_job(mk(32'h100, 32'h200, 32'd4, 32'h8, 32'h8, 32'h0, 32'h0, 2, 1), -1);
    send_job(mk(32'h300, 32'h400, 32'd4, 32'h8, 32'h8, 32'h0, 32'h0, 2, 1), -1);
    r3 = mk(32'h500, 32'h600, 32'd4, 32'h8, 32'h8, 32'h0, 32'h0, 2, 1);
    expect_job(r3, -1);
    bus_if.nd_req       = r3;
    bus_if.nd_req_valid = 1'b1;
    repeat (8) @(negedge clk);
    check_eq("t5_stalled_ready", bus_if.nd_req_ready, 0);
    check_eq("t5_no_rsp_yet", bus_if.nd_rsp_valid, 0);
    rsp_en = 1'b1;
    drive_job(r3);
    check_eq("t5_accept_after_first", exp_nd_q.size(), 2);
    drain("t5");

    // 6: unacknowledged ND response holds off burst responses
    bus_if.nd_rsp_ready = 1'b0;
    send_job(mk(32'h700, 32'h800, 32'd4, 32'h8, 32'h8, 32'h0, 32'h0, 2, 1), 0);
    send_job(mk(32'h900, 32'ha00, 32'd4, 32'h8, 32'h8, 32'h0, 32'h0, 2, 1), -1);
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      @(negedge clk);
      if (bus_if.nd_rsp_valid) found = 1'b1;
    end
    check_eq("t6_rsp_seen", found, 1);
    err0   = bus_if.nd_rsp.error;
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!bus_if.nd_rsp_valid || bus_if.nd_rsp.error !== err0 || bus_if.burst_rsp_ready)
        stable = 1'b0;
    end
    check_eq("t6_held_stable", stable, 1);
    check_eq("t6_rsp_error", err0, 1);
    check_eq("t6_pending_rsps", pend_rsp_q.size(), 2);
    @(posedge clk);
    #1 bus_if.nd_rsp_ready = 1'b1;
    drain("t6");

    // 7: reset while issuing, then a fresh job
    bus_if.burst_req_ready = 1'b0;
    drive_job(mk(32'hA000, 32'hB000, 32'd4, 32'h8, 32'h8, 32'h0, 32'h0, 4, 1));
    repeat (2) @(posedge clk);
    #1;
    check_eq("t7_busy_before_rst", busy, 1);
    rst_n = 1'b0;
    exp_burst_q.delete();
    exp_nd_q.delete();
    pend_rsp_q.delete();
    bus_if.burst_rsp_valid = 1'b0;
    @(negedge clk);
    check_eq("t7_rst_burst_valid", bus_if.burst_req_valid, 0);
    check_eq("t7_rst_nd_rsp_valid", bus_if.nd_rsp_valid, 0);
    check_eq("t7_rst_busy", busy, 0);
    @(posedge clk);
    #1;
    rst_n                  = 1'b1;
    bus_if.burst_req_ready = 1'b1;
    send_job(mk(32'hC000, 32'hD000, 32'd8, 32'h40, 32'h80, 32'h400, 32'h800, 2, 2), 3);
    drain("t7");

    // 8: random backpressure on bursts and responses
    rand_bp = 1'b1;
    for (int n = 0; n < 6; n++) begin
      r = mk($urandom, $urandom, addr_t'($urandom_range(1, 256)), $urandom, $urandom,
             $urandom, $urandom, reps_t'($urandom_range(1, 3)), reps_t'($urandom_range(1, 3)));
      send_job(r, (n % 2 == 0) ? -1 : int'($urandom_range(0, 3)));
    end
    drain("t8");
    rand_bp                = 1'b0;
    bus_if.burst_req_ready = 1'b1;

    check_eq("end_pending_rsps", pend_rsp_q.size(), 0);
    check_eq("end_busy", busy, 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
